// File: rtl/add_disp_seq.sv
// add_disp_seq: sequential front end for the 4-bit sum/carry display mux.
//
// A start press latches operands A and B. The block then computes a registered
// 4-bit sum with carry-out and alternates Sel between showing the sum (Sel=1)
// and the carry (Sel=0). Each display phase lasts DWELL_CYCLES clocks.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   A, B   in   4-bit operands, sampled only in CAPTURE
//   start  in   asynchronous start button, active-high
//   S      out  registered sum
//   Cout   out  registered carry-out
//   Sel    out  display select (1 = S, 0 = Cout)
//   valid  out  high while S/Cout hold a completed result
//
// Optional feature: define ADD_DISP_SEQ_DEBOUNCE_EN to insert a debounce
// counter of DEBOUNCE_CYCLES between the start synchroniser and the edge
// detector. The feature is absent by default.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | after reset, waiting for the first press
// ST_CAPTURE   | latch A/B, drop valid
// ST_ADD       | register the sum and carry, start the dwell
// ST_SHOW_SUM  | Sel=1, count the dwell
// ST_SHOW_COUT | Sel=0, count the dwell

module add_disp_seq #(
    parameter int unsigned DWELL_CYCLES    = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       start,
    output logic [3:0] S,
    output logic       Cout,
    output logic       Sel,
    output logic       valid
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ADD,
        ST_SHOW_SUM,
        ST_SHOW_COUT
    } state_e;

    state_e state_q, state_d;

    logic sync1_q, sync2_q;
    logic start_lvl;
    logic edge_q;
    logic start_pulse;

    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             cout_q, cout_d;
    logic             sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       sum;
    logic             dwell_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= start;
            sync2_q <= sync1_q;
        end
    end

`ifdef ADD_DISP_SEQ_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q;
    logic            db_lvl_q;

    // Counts consecutive cycles where the synchronised input disagrees with the
    // debounced level. Any agreeing cycle clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else if (sync2_q == db_lvl_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_TC) begin
            db_cnt_q <= '0;
            db_lvl_q <= sync2_q;
        end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    assign start_lvl = db_lvl_q;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign start_lvl = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= start_lvl;
        end
    end

    assign start_pulse = start_lvl & ~edge_q;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign dwell_tc = (cnt_q == CNT_TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A press during a display phase outranks the dwell terminal count.
    // A press during CAPTURE or ADD is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (start_pulse) state_d = ST_CAPTURE;
            ST_CAPTURE:   state_d = ST_ADD;
            ST_ADD:       state_d = ST_SHOW_SUM;
            ST_SHOW_SUM:  if (start_pulse) state_d = ST_CAPTURE;
                          else if (dwell_tc) state_d = ST_SHOW_COUT;
            ST_SHOW_COUT: if (start_pulse) state_d = ST_CAPTURE;
                          else if (dwell_tc) state_d = ST_SHOW_SUM;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CAPTURE: begin
                a_d     = A;
                b_d     = B;
                valid_d = 1'b0;
            end
            ST_ADD: begin
                s_d     = sum[3:0];
                cout_d  = sum[4];
                valid_d = 1'b1;
                sel_d   = 1'b1;
                cnt_d   = '0;
            end
            ST_SHOW_SUM, ST_SHOW_COUT: begin
                if (!start_pulse) begin
                    if (dwell_tc) begin
                        cnt_d = '0;
                        sel_d = (state_q == ST_SHOW_COUT);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            sel_q   <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S     = s_q;
    assign Cout  = cout_q;
    assign Sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_add_disp_seq.sv
module tb_add_disp_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       start;
    logic [3:0] S;
    logic       Cout;
    logic       Sel;
    logic       valid;

    int checks = 0;
    int errors = 0;

    add_disp_seq #(
        .DWELL_CYCLES    (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .start (start),
        .S     (S),
        .Cout  (Cout),
        .Sel   (Sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        A     = 4'd0;
        B     = 4'd0;

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_S",     {4'd0, S},     8'd0);
        check("rst_Cout",  {7'd0, Cout},  8'd0);
        check("rst_Sel",   {7'd0, Sel},   8'd1);
        check("rst_valid", {7'd0, valid}, 8'd0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("idle_valid", {7'd0, valid}, 8'd0);
        check("idle_Sel",   {7'd0, Sel},   8'd1);
        check("idle_S",     {4'd0, S},     8'd0);

        // Basic add 3+4.
        A = 4'd3; B = 4'd4;
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(2);
        check("basic_valid_e4", {7'd0, valid}, 8'd0);
        step(1);
        check("basic_S",     {4'd0, S},     8'd7);
        check("basic_Cout",  {7'd0, Cout},  8'd0);
        check("basic_valid", {7'd0, valid}, 8'd1);
        check("basic_Sel",   {7'd0, Sel},   8'd1);
        A = 4'd0; B = 4'd0;
        step(3);
        check("basic_Sel_e8",  {7'd0, Sel}, 8'd1);
        step(1);
        check("basic_Sel_e9",  {7'd0, Sel}, 8'd0);
        check("basic_S_hold",  {4'd0, S},   8'd7);
        step(3);
        check("basic_Sel_e12", {7'd0, Sel}, 8'd0);
        step(1);
        check("basic_Sel_e13", {7'd0, Sel}, 8'd1);

        // Reset in the middle of SHOW_SUM.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_S",     {4'd0, S},     8'd0);
        check("midrst_Cout",  {7'd0, Cout},  8'd0);
        check("midrst_Sel",   {7'd0, Sel},   8'd1);
        check("midrst_valid", {7'd0, valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(10);
        check("postrst_valid", {7'd0, valid}, 8'd0);
        check("postrst_S",     {4'd0, S},     8'd0);
        check("postrst_Sel",   {7'd0, Sel},   8'd1);

        // Overflow 15+15.
        A = 4'd15; B = 4'd15;
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(3);
        check("ovf_S",     {4'd0, S},     8'd14);
        check("ovf_Cout",  {7'd0, Cout},  8'd1);
        check("ovf_valid", {7'd0, valid}, 8'd1);
        check("ovf_Sel",   {7'd0, Sel},   8'd1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("ovf_Sel_pattern", {7'd0, Sel}, (i < 3 || i == 7) ? 8'd1 : 8'd0);
        end

        // Restart during SHOW_COUT, landing on the dwell terminal count.
        // After edge 13 of this transaction: SHOW_SUM, count 0.
        step(5);
        A = 4'd9; B = 4'd8;
        start = 1'b1;
        step(3);
        check("rs_Sel_capture",   {7'd0, Sel},   8'd0);
        check("rs_valid_capture", {7'd0, valid}, 8'd1);
        step(1);
        check("rs_valid_add", {7'd0, valid}, 8'd0);
        check("rs_S_old",     {4'd0, S},     8'd14);
        check("rs_Cout_old",  {7'd0, Cout},  8'd1);
        step(1);
        check("rs_S",     {4'd0, S},     8'd1);
        check("rs_Cout",  {7'd0, Cout},  8'd1);
        check("rs_valid", {7'd0, valid}, 8'd1);
        check("rs_Sel",   {7'd0, Sel},   8'd1);
        step(3);
        check("rs_Sel_dwell_end", {7'd0, Sel}, 8'd1);
        step(1);
        check("rs_Sel_toggle", {7'd0, Sel}, 8'd0);
        for (int i = 0; i < 11; i++) begin
            step(1);
            check("hold_one_pulse_valid", {7'd0, valid}, 8'd1);
        end
        start = 1'b0;
        step(5);
        check("hold_release_valid", {7'd0, valid}, 8'd1);
        check("hold_release_S",     {4'd0, S},     8'd1);

        // Second pulse lands in ADD and is dropped.
        A = 4'd1; B = 4'd2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check("drop_S",        {4'd0, S},     8'd3);
        check("drop_valid_e5", {7'd0, valid}, 8'd1);
        step(1);
        check("drop_valid_e6", {7'd0, valid}, 8'd1);
        step(1);
        check("drop_valid_e7", {7'd0, valid}, 8'd1);
        check("drop_Sel_e7",   {7'd0, Sel},   8'd1);

        // Two-cycle glitch on start.
        A = 4'd6; B = 4'd7;
        step(10);
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(3);
`ifdef ADD_DISP_SEQ_DEBOUNCE_EN
        check("glitch_S",     {4'd0, S},     8'd3);
        check("glitch_valid", {7'd0, valid}, 8'd1);
        step(10);
        check("glitch_S_late", {4'd0, S}, 8'd3);

        // Long press: valid after DEBOUNCE_CYCLES+5 = 8 edges.
        A = 4'd10; B = 4'd4;
        start = 1'b1;
        step(7);
        check("deb_S_e7", {4'd0, S}, 8'd3);
        step(1);
        check("deb_S_e8",     {4'd0, S},     8'd14);
        check("deb_Cout_e8",  {7'd0, Cout},  8'd0);
        check("deb_valid_e8", {7'd0, valid}, 8'd1);
        start = 1'b0;
        step(10);
        check("deb_valid_after", {7'd0, valid}, 8'd1);
`else
        check("glitch_S",     {4'd0, S},     8'd13);
        check("glitch_Cout",  {7'd0, Cout},  8'd0);
        check("glitch_valid", {7'd0, valid}, 8'd1);
        check("glitch_Sel",   {7'd0, Sel},   8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
